// File: rtl/vga_pkg.sv
// Shared encodings for the VGA pattern sequencer: pattern codes, FSM states, rotation end.
// VGA_PATTERN_BARS_EN adds the colour-bars pattern to the rotation.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_RUN        = 2'd2,
    ST_PAUSE      = 2'd3
  } seq_state_e;

  localparam logic [1:0] PAT_RED   = 2'd0;
  localparam logic [1:0] PAT_GREEN = 2'd1;
  localparam logic [1:0] PAT_BLUE  = 2'd2;
  localparam logic [1:0] PAT_BARS  = 2'd3;

`ifdef VGA_PATTERN_BARS_EN
  localparam logic [1:0] LAST_PATTERN = PAT_BARS;
`else
  localparam logic [1:0] LAST_PATTERN = PAT_BLUE;
`endif

  function automatic logic [1:0] next_pattern(input logic [1:0] pat);
    if (pat >= LAST_PATTERN) begin
      return PAT_RED;
    end else begin
      return pat + 2'd1;
    end
  endfunction

endpackage

// File: rtl/frame_dwell_counter.sv
// Counts frames spent on the current pattern; expire flags the last frame of the dwell.
module frame_dwell_counter
  import vga_pkg::*;
#(
  parameter int DWELL_FRAMES = 60,
  parameter int CNT_W        = 8
) (
  input  logic             pixel_clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic             expire,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_FRAMES - 1);

  logic [CNT_W-1:0] count_r;

  assign expire = (count_r == LAST_CNT);
  assign count  = count_r;

  // Frame counter register: clear wins, wraps to zero on the expiring increment.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (inc) begin
      count_r <= expire ? '0 : count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Cycles test patterns on frame boundaries with pause and manual-step control.
// Define VGA_PATTERN_BARS_EN to include BARS in the rotation.
module vga_pattern_sequencer
  import vga_pkg::*;
#(
  parameter int DWELL_FRAMES = 60,
  parameter int CNT_W        = 8
) (
  input  logic             pixel_clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             enable,
  input  logic             pause,
  input  logic             step_req,
  output logic             step_ack,
  output logic [1:0]       pattern_sel,
  output logic             pattern_valid,
  output logic [CNT_W-1:0] frame_cnt
);

  seq_state_e state_r, state_s;
  logic [1:0] pattern_r, pattern_s;
  logic       pending_r, pending_s;
  logic       ack_r, ack_s;
  logic       valid_r, valid_s;
  logic       clear_s, inc_s, expire_s, apply_step_s;

  frame_dwell_counter #(
    .DWELL_FRAMES(DWELL_FRAMES),
    .CNT_W       (CNT_W)
  ) u_dwell (
    .pixel_clk(pixel_clk),
    .rst_n    (rst_n),
    .clear    (clear_s),
    .inc      (inc_s),
    .expire   (expire_s),
    .count    (frame_cnt)
  );

  // A pending step always consumes the frame boundary, so it can never stack with a dwell advance.
  assign apply_step_s = frame_start && pending_r &&
                        ((state_r == ST_RUN) || (state_r == ST_PAUSE));

  // Next-state, pattern, step handshake and counter control.
  always_comb begin
    state_s   = state_r;
    pattern_s = pattern_r;
    pending_s = pending_r;
    ack_s     = 1'b0;
    clear_s   = 1'b0;
    inc_s     = 1'b0;
    if (!enable) begin
      state_s   = ST_IDLE;
      pattern_s = PAT_RED;
      pending_s = 1'b0;
      clear_s   = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_WAIT_FRAME;
        end
        ST_WAIT_FRAME: begin
          if (frame_start) begin
            state_s   = ST_RUN;
            pattern_s = PAT_RED;
            clear_s   = 1'b1;
          end else begin
            state_s = ST_WAIT_FRAME;
          end
        end
        ST_RUN, ST_PAUSE: begin
          state_s = pause ? ST_PAUSE : ST_RUN;
          if (apply_step_s) begin
            pattern_s = next_pattern(pattern_r);
            pending_s = 1'b0;
            ack_s     = 1'b1;
            clear_s   = 1'b1;
          end else begin
            pending_s = pending_r | step_req;
            if (frame_start && (state_r == ST_RUN)) begin
              inc_s     = 1'b1;
              pattern_s = expire_s ? next_pattern(pattern_r) : pattern_r;
            end else begin
              inc_s     = 1'b0;
              pattern_s = pattern_r;
            end
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
    valid_s = (state_s == ST_RUN) || (state_s == ST_PAUSE);
  end

  // State and registered outputs.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      pattern_r <= PAT_RED;
      pending_r <= 1'b0;
      ack_r     <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      pattern_r <= pattern_s;
      pending_r <= pending_s;
      ack_r     <= ack_s;
      valid_r   <= valid_s;
    end
  end

  assign step_ack      = ack_r;
  assign pattern_sel   = pattern_r;
  assign pattern_valid = valid_r;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Self-checking bench for vga_pattern_sequencer: vector table, directed corner cases, random vs model.
module tb_vga_pattern_sequencer;

  localparam int DWELL = 3;
  localparam int CW    = 8;
`ifdef VGA_PATTERN_BARS_EN
  localparam int NPAT = 4;
`else
  localparam int NPAT = 3;
`endif

  logic          pixel_clk = 1'b0;
  logic          rst_n;
  logic          frame_start, enable, pause, step_req;
  logic          step_ack, pattern_valid;
  logic [1:0]    pattern_sel;
  logic [CW-1:0] frame_cnt;

  vga_pattern_sequencer #(.DWELL_FRAMES(DWELL), .CNT_W(CW)) dut (
    .pixel_clk    (pixel_clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .enable       (enable),
    .pause        (pause),
    .step_req     (step_req),
    .step_ack     (step_ack),
    .pattern_sel  (pattern_sel),
    .pattern_valid(pattern_valid),
    .frame_cnt    (frame_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: mode 0 idle, 1 waiting for frame, 2 running, 3 paused.
  int m_mode, m_pat, m_cnt;
  bit m_pend, m_ack;

  task automatic model_reset();
    m_mode = 0; m_pat = 0; m_cnt = 0; m_pend = 0; m_ack = 0;
  endtask

  task automatic model_edge(input bit fs, input bit en, input bit pz, input bit sr);
    m_ack = 0;
    if (!en) begin
      m_mode = 0; m_pat = 0; m_cnt = 0; m_pend = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (fs) begin m_mode = 2; m_pat = 0; m_cnt = 0; end
    end else begin
      if (fs && m_pend) begin
        m_pat = (m_pat + 1) % NPAT; m_cnt = 0; m_pend = 0; m_ack = 1;
      end else begin
        if (sr) m_pend = 1;
        if (fs && m_mode == 2) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == DWELL) begin m_cnt = 0; m_pat = (m_pat + 1) % NPAT; end
        end
      end
      m_mode = pz ? 3 : 2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic tick(input bit fs, input bit en, input bit pz, input bit sr);
    frame_start = fs; enable = en; pause = pz; step_req = sr;
    @(posedge pixel_clk);
    model_edge(fs, en, pz, sr);
    #1;
    frame_start = 1'b0; step_req = 1'b0;
  endtask

  task automatic chk_out(input string name, input int pat, input int cnt, input bit valid, input bit ack);
    chk({name, ".pat"},   pattern_sel,   pat);
    chk({name, ".cnt"},   frame_cnt,     cnt);
    chk({name, ".valid"}, pattern_valid, valid);
    chk({name, ".ack"},   step_ack,      ack);
  endtask

  task automatic restart();
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    tick(1, 1, 0, 0);
  endtask

  typedef struct {
    bit fs, en, pz, sr;
    int pat, cnt;
    bit valid, ack;
  } vec_t;

  vec_t tbl[16];
  int   wrap_pat;
  bit   pz_lvl;

  initial begin
    wrap_pat = (NPAT == 4) ? 3 : 0;
    // fs en pz sr | pat cnt valid ack
    tbl[0]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 1, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 0, 1, 0};
    tbl[3]  = '{1, 1, 0, 0, 0, 1, 1, 0};
    tbl[4]  = '{1, 1, 0, 0, 0, 2, 1, 0};
    tbl[5]  = '{1, 1, 0, 0, 1, 0, 1, 0};
    tbl[6]  = '{1, 1, 0, 0, 1, 1, 1, 0};
    tbl[7]  = '{1, 1, 0, 0, 1, 2, 1, 0};
    tbl[8]  = '{1, 1, 0, 0, 2, 0, 1, 0};
    tbl[9]  = '{1, 1, 0, 0, 2, 1, 1, 0};
    tbl[10] = '{1, 1, 0, 0, 2, 2, 1, 0};
    tbl[11] = '{1, 1, 0, 0, wrap_pat, 0, 1, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 1, 0, 1, 0, 0, 0, 0};
    tbl[14] = '{1, 1, 0, 0, 0, 0, 1, 0};
    tbl[15] = '{1, 1, 0, 0, 0, 1, 1, 0};

    rst_n = 1'b0; frame_start = 1'b0; enable = 1'b0; pause = 1'b0; step_req = 1'b0;
    model_reset();
    #12 rst_n = 1'b1;
    chk_out("reset", 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].fs, tbl[i].en, tbl[i].pz, tbl[i].sr);
      chk_out($sformatf("tbl%0d", i), tbl[i].pat, tbl[i].cnt, tbl[i].valid, tbl[i].ack);
    end

    // pause freezes count and pattern, count resumes from frozen value
    restart();
    tick(1, 1, 0, 0);
    tick(0, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1, 1, 1, 0);
      chk_out("pause_hold", 0, 1, 1, 0);
    end
    tick(0, 1, 0, 0);
    tick(1, 1, 0, 0);
    chk_out("pause_resume", 0, 2, 1, 0);
    tick(1, 1, 0, 0);
    chk_out("pause_expire", 1, 0, 1, 0);

    // step while paused, second request dropped
    tick(0, 1, 1, 0);
    tick(0, 1, 1, 1);
    tick(0, 1, 1, 1);
    chk("step_no_early_ack", step_ack, 0);
    tick(1, 1, 1, 0);
    chk_out("step_apply", 2, 0, 1, 1);
    tick(0, 1, 1, 0);
    chk("step_ack_once", step_ack, 0);
    tick(1, 1, 1, 0);
    chk_out("step_no_second", 2, 0, 1, 0);
    tick(0, 1, 0, 0);

    // step_req coinciding with frame_start lands on the following frame
    tick(1, 1, 0, 1);
    chk_out("step_same_cycle", 2, 1, 1, 0);
    tick(1, 1, 0, 0);
    chk_out("step_next_frame", wrap_pat, 0, 1, 1);

    // step and dwell expiry coincide: single advance
    restart();
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    chk("coinc_cnt2", frame_cnt, 2);
    tick(0, 1, 0, 1);
    tick(1, 1, 0, 0);
    chk_out("coinc_apply", 1, 0, 1, 1);
    tick(1, 1, 0, 0);
    chk_out("coinc_after", 1, 1, 1, 0);

    // enable drop mid-frame, re-enable needs a frame_start
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    chk("en_pre_pat2", pattern_sel, 2);
    tick(0, 0, 0, 0);
    chk_out("en_drop", 0, 0, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    chk("en_wait_valid", pattern_valid, 0);
    tick(1, 1, 0, 0);
    chk_out("en_run", 0, 0, 1, 0);

    // asynchronous reset while running
    tick(1, 1, 0, 0);
    tick(0, 1, 0, 1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk_out("async_rst", 0, 0, 0, 0);
    @(posedge pixel_clk);
    #2 rst_n = 1'b1;
    tick(0, 1, 0, 1);
    chk_out("idle_step", 0, 0, 0, 0);
    tick(1, 1, 0, 0);
    chk_out("rst_rerun", 0, 0, 1, 0);
    tick(1, 1, 0, 0);
    chk_out("rst_no_pend", 0, 1, 1, 0);

    // randomized run against the model
    pz_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) pz_lvl = ~pz_lvl;
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 39) != 0, pz_lvl, $urandom_range(0, 7) == 0);
      chk_out("rand", m_pat, m_cnt, (m_mode >= 2), m_ack);
`ifndef VGA_PATTERN_BARS_EN
      chk("rand_no_bars", (pattern_sel == 2'd3), 0);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/vga_pattern_sequencer.md
VGA_PATTERN_SEQUENCER -- requirements
Module: vga_pattern_sequencer

Interface
REQ-001 Parameter DWELL_FRAMES, default 60; the number of frames each pattern is held in auto mode, legal range 1..255.
REQ-002 Parameter CNT_W, default 8; the width of frame_cnt.
REQ-003 pixel_clk  input  1  pixel clock; the only clock in the block.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 frame_start  input  1  one-cycle pulse at the first active pixel of each frame, from the VGA timing controller.
REQ-006 enable  input  1  level; 1 = sequencer runs, 0 = sequencer returns to idle.
REQ-007 pause  input  1  level; 1 = freeze auto advance.
REQ-008 step_req  input  1  one-cycle pulse requesting a manual advance to the next pattern.
REQ-009 step_ack  output  1  one-cycle pulse in the cycle a step is applied.
REQ-010 pattern_sel  output  2  current pattern: 0 RED, 1 GREEN, 2 BLUE, 3 BARS.
REQ-011 pattern_valid  output  1  1 in RUN or PAUSE states.
REQ-012 frame_cnt  output  CNT_W  frames elapsed in the current pattern.

Function
REQ-013 The FSM SHALL have four states: IDLE, WAIT_FRAME, RUN and PAUSE.
REQ-014 IDLE SHALL go to WAIT_FRAME when enable=1.
REQ-015 WAIT_FRAME SHALL go to RUN on frame_start, with frame_cnt=0 and pattern_sel=0.
REQ-016 RUN SHALL go to PAUSE when pause=1; PAUSE SHALL go to RUN when pause=0.
REQ-017 enable=0 in any state SHALL force IDLE on the next edge, with pattern_sel=0, frame_cnt=0 and a pending step cleared.
REQ-018 In RUN, each frame_start SHALL increment frame_cnt.
REQ-019 In RUN, when frame_start arrives with frame_cnt==DWELL_FRAMES-1, the block SHALL set frame_cnt=0 and advance pattern_sel.
REQ-020 Advance SHALL be pattern_sel+1, wrapping from the last enabled pattern to 0.
REQ-021 In PAUSE, frame_cnt and pattern_sel SHALL hold.
REQ-022 A step_req in RUN or PAUSE SHALL set a pending flag.
REQ-023 On the next frame_start with the flag set, the block SHALL advance the pattern, zero frame_cnt, clear the flag and pulse step_ack in that same cycle.
REQ-024 step_req while a step is already pending SHALL be dropped.
REQ-025 step_req in IDLE or WAIT_FRAME SHALL be ignored and SHALL produce no ack.
REQ-026 When a step and a dwell expiry coincide, the pattern SHALL advance exactly once.
REQ-027 When step_req and frame_start arrive in the same cycle, the step SHALL be applied at the following frame_start.
REQ-028 Priority SHALL be: enable=0 over step over dwell expiry.
REQ-029 All outputs SHALL be registered, so pattern_sel changes one cycle after the sampled frame_start and never mid-frame.

Reset
REQ-030 While rst_n=0, the block SHALL set state=IDLE, pattern_sel=0, frame_cnt=0, step_ack=0, pattern_valid=0 and pending=0.
REQ-031 Reset asserted mid-frame SHALL take effect immediately; the sequence SHALL restart from RED only via WAIT_FRAME.

Configuration
REQ-032 With macro VGA_PATTERN_BARS_EN defined, the rotation SHALL be RED, GREEN, BLUE, BARS.
REQ-033 Without VGA_PATTERN_BARS_EN, the rotation SHALL be RED, GREEN, BLUE, and pattern_sel SHALL never equal 3.

Structure
REQ-034 A shared package vga_pkg SHALL hold the pattern encodings (PAT_RED, PAT_GREEN, PAT_BLUE, PAT_BARS), the FSM state typedef and the LAST_PATTERN constant derived from the macro.
REQ-035 The frame counter SHALL be one sub-module, frame_dwell_counter, with ports clear, inc and expire.
REQ-036 The FSM, step handshake and pattern register SHALL live in the top module.

Verification
REQ-037 Use DWELL_FRAMES=3, enable=1 and 10 frame_start pulses -> pattern_sel steps 0,0,0,1,1,1,2,2,2,3 with BARS_EN defined, or 0,0,0,1,1,1,2,2,2,0 without it.
REQ-038 Assert pause after frame 2 for 5 frames -> pattern_sel and frame_cnt frozen; the count resumes from the frozen value after release.
REQ-039 Pulse step_req in PAUSE, then one frame_start -> step_ack high for exactly 1 cycle, pattern_sel+1, frame_cnt=0; a second step_req before that frame_start -> no additional ack.
REQ-040 With frame_cnt=2 and DWELL_FRAMES=3, apply step_req then frame_start -> a single advance (0->1) and one ack.
REQ-041 Drop enable mid-frame with pattern_sel=2 -> next cycle IDLE, pattern_sel=0, pattern_valid=0; re-enable -> RUN only after the next frame_start.
REQ-042 Pulse rst_n low for 1 cycle while in RUN -> all outputs zero asynchronously; step_req in IDLE -> no ack.
